// File: rtl/ups_axi4l_pkg.sv
// Shared types for the UPS AXI4-Lite command master.
// Response codes and the master FSM state encoding.
package ups_axi4l_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_B,
    S_RD_A,
    S_RD_R,
    S_RSP
  } axi4l_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ups_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Pointers carry an extra MSB to tell full from empty.
module ups_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      wptr_n;
  logic [AW:0]      rptr_n;
  logic             do_push;
  logic             do_pop;
  logic             full_nxt;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wptr_n  = wptr + (AW+1)'(do_push);
  assign rptr_n  = rptr + (AW+1)'(do_pop);

  assign empty_nxt = (wptr_n == rptr_n);
  assign full_nxt  = (wptr_n[AW] != rptr_n[AW]) &&
                     (wptr_n[AW-1:0] == rptr_n[AW-1:0]);

  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge fclk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      full  <= full_nxt;
      empty <= empty_nxt;
    end
  end

  always_ff @(posedge fclk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ups_axi4l_cmd_master.sv
// AXI4-Lite master draining a command FIFO, one transaction
// in flight, with a per-phase timeout for bring-up recovery.
module ups_axi4l_cmd_master
  import ups_axi4l_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 4,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [2:0]  PROT        = 3'b000
) (
  input  logic                fclk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_wr,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                busy,
  output logic [ADDR_W-1:0]   ca4l_awaddr,
  output logic [2:0]          ca4l_awprot,
  output logic                ca4l_awvalid,
  input  logic                ca4l_awready,
  output logic [DATA_W-1:0]   ca4l_wdata,
  output logic [DATA_W/8-1:0] ca4l_wstrb,
  output logic                ca4l_wvalid,
  input  logic                ca4l_wready,
  input  logic [1:0]          ca4l_bresp,
  input  logic                ca4l_bvalid,
  output logic                ca4l_bready,
  output logic [ADDR_W-1:0]   ca4l_araddr,
  output logic [2:0]          ca4l_arprot,
  output logic                ca4l_arvalid,
  input  logic                ca4l_arready,
  input  logic [DATA_W-1:0]   ca4l_rdata,
  input  logic [1:0]          ca4l_rresp,
  input  logic                ca4l_rvalid,
  output logic                ca4l_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_w(TIMEOUT_CYC);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  cmd_t         push_cmd;
  cmd_t         head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_empty_nxt;
  logic         launch;
  logic         idle_nxt;
  logic         in_phase;
  logic         hs_done;
  logic         tmo;
  logic [CNT_W-1:0] tcnt;
  axi4l_state_t state;

  assign push_cmd = '{wr: cmd_wr, addr: cmd_addr,
                      data: cmd_data, strb: cmd_strb};

  ups_sync_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .fclk      (fclk),
    .rst       (rst),
    .push      (cmd_valid),
    .wdata     (push_cmd),
    .pop       (launch),
    .rdata     (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .empty_nxt (fifo_empty_nxt)
  );

  assign cmd_ready   = !fifo_full;
  assign ca4l_awprot = PROT;
  assign ca4l_arprot = PROT;

  // A response handshake may hand straight over to the next command.
  assign launch   = !fifo_empty &&
                    (state == S_IDLE || (state == S_RSP && rsp_ready));
  assign idle_nxt = fifo_empty &&
                    (state == S_IDLE || (state == S_RSP && rsp_ready));
  assign tmo      = (tcnt == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    hs_done  = 1'b0;
    in_phase = 1'b1;
    unique case (1'b1)
      (state == S_WR):
        hs_done = (!ca4l_awvalid || ca4l_awready) &&
                  (!ca4l_wvalid || ca4l_wready);
      (state == S_WR_B): hs_done = ca4l_bvalid;
      (state == S_RD_A): hs_done = ca4l_arready;
      (state == S_RD_R): hs_done = ca4l_rvalid;
      default:           in_phase = 1'b0;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state        <= S_IDLE;
      tcnt         <= '0;
      ca4l_awaddr  <= '0;
      ca4l_awvalid <= 1'b0;
      ca4l_wdata   <= '0;
      ca4l_wstrb   <= '0;
      ca4l_wvalid  <= 1'b0;
      ca4l_bready  <= 1'b0;
      ca4l_araddr  <= '0;
      ca4l_arvalid <= 1'b0;
      ca4l_rready  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_wr       <= 1'b0;
      rsp_data     <= '0;
      rsp_resp     <= '0;
      rsp_timeout  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        S_WR: begin
          if (ca4l_awready) ca4l_awvalid <= 1'b0;
          if (ca4l_wready)  ca4l_wvalid  <= 1'b0;
          if (hs_done) begin
            state       <= S_WR_B;
            ca4l_bready <= 1'b1;
          end
        end
        S_WR_B: if (ca4l_bvalid) begin
          ca4l_bready <= 1'b0;
          state       <= S_RSP;
          rsp_valid   <= 1'b1;
          rsp_wr      <= 1'b1;
          rsp_resp    <= ca4l_bresp;
          rsp_data    <= '0;
          rsp_timeout <= 1'b0;
        end
        S_RD_A: if (ca4l_arready) begin
          ca4l_arvalid <= 1'b0;
          ca4l_rready  <= 1'b1;
          state        <= S_RD_R;
        end
        S_RD_R: if (ca4l_rvalid) begin
          ca4l_rready <= 1'b0;
          state       <= S_RSP;
          rsp_valid   <= 1'b1;
          rsp_wr      <= 1'b0;
          rsp_resp    <= ca4l_rresp;
          rsp_data    <= ca4l_rdata;
          rsp_timeout <= 1'b0;
        end
        S_RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: ;
      endcase

      if (in_phase) tcnt <= hs_done ? '0 : tcnt + CNT_W'(1);

      // Abandon the phase; a late slave beat is simply not accepted.
      if (in_phase && !hs_done && tmo) begin
        ca4l_awvalid <= 1'b0;
        ca4l_wvalid  <= 1'b0;
        ca4l_bready  <= 1'b0;
        ca4l_arvalid <= 1'b0;
        ca4l_rready  <= 1'b0;
        state        <= S_RSP;
        rsp_valid    <= 1'b1;
        rsp_wr       <= (state == S_WR) || (state == S_WR_B);
        rsp_resp     <= RESP_SLVERR;
        rsp_data     <= '0;
        rsp_timeout  <= 1'b1;
      end

      if (launch) begin
        tcnt <= '0;
        if (head.wr) begin
          state        <= S_WR;
          ca4l_awaddr  <= head.addr;
          ca4l_wdata   <= head.data;
          ca4l_wstrb   <= head.strb;
          ca4l_awvalid <= 1'b1;
          ca4l_wvalid  <= 1'b1;
        end else begin
          state        <= S_RD_A;
          ca4l_araddr  <= head.addr;
          ca4l_arvalid <= 1'b1;
        end
      end

      busy <= !(fifo_empty_nxt && idle_nxt);
    end
  end

endmodule
